// File: rtl/kara_seq_mult.sv
// Sequential Karatsuba multiplier: one shared (K/2+1)x(K/2+1) multiplier core computes
// p, q, t over three cycles, then a combine cycle forms the 2K-bit product.
module kara_seq_mult #(
    parameter int unsigned K = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K-1:0]   x,
    input  logic [K-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*K-1:0] z,
    output logic           busy
);
    localparam int unsigned H  = K / 2;
    localparam int unsigned MW = H + 1;
    localparam int unsigned PW = 2 * MW;
    localparam int unsigned ZW = 2 * K;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_MUL_P   = 6'b000010,
        S_MUL_Q   = 6'b000100,
        S_MUL_T   = 6'b001000,
        S_COMBINE = 6'b010000,
        S_DONE    = 6'b100000
    } state_t;

    state_t state, state_n;

    logic [K-1:0]  x_q, y_q;
    logic [H:0]    r, s;
    logic [2*H-1:0] p, q;
    logic [PW-1:0] t;
    logic [MW-1:0] mul_a, mul_b;
    logic [PW-1:0] mul_y;
    logic [K+1:0]  mid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:    if (in_valid)  state_n = S_MUL_P;
            S_MUL_P:   state_n = S_MUL_Q;
            S_MUL_Q:   state_n = S_MUL_T;
            S_MUL_T:   state_n = S_COMBINE;
            S_COMBINE: state_n = S_DONE;
            S_DONE:    if (out_ready) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Handshake/status outputs decode straight from the state flops
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        if (state == S_IDLE) begin
            in_ready = 1'b1;
            busy     = 1'b0;
        end
        if (state == S_DONE) out_valid = 1'b1;
    end

    // Shared multiplier core: operands selected by the current step
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state)
            S_MUL_P: begin
                mul_a = {1'b0, x_q[K-1:H]};
                mul_b = {1'b0, y_q[K-1:H]};
            end
            S_MUL_Q: begin
                mul_a = {1'b0, x_q[H-1:0]};
                mul_b = {1'b0, y_q[H-1:0]};
            end
            S_MUL_T: begin
                mul_a = r;
                mul_b = s;
            end
            default: ;
        endcase
    end

    assign mul_y = PW'(mul_a) * PW'(mul_b);

    // Middle term t - p - q is non-negative; two spare bits keep every step from wrapping
    assign mid = (K+2)'(t) - (K+2)'(p) - (K+2)'(q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            r   <= '0;
            s   <= '0;
            p   <= '0;
            q   <= '0;
            t   <= '0;
            z   <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (in_valid) begin
                    x_q <= x;
                    y_q <= y;
                    r   <= (H+1)'(x[K-1:H]) + (H+1)'(x[H-1:0]);
                    s   <= (H+1)'(y[K-1:H]) + (H+1)'(y[H-1:0]);
                end
                S_MUL_P:   p <= mul_y[2*H-1:0];
                S_MUL_Q:   q <= mul_y[2*H-1:0];
                S_MUL_T:   t <= mul_y;
                S_COMBINE: z <= ZW'(((ZW+1)'(p) << K) + ((ZW+1)'(mid) << H) + (ZW+1)'(q));
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kara_seq_mult.sv
// Randomized self-checking bench for kara_seq_mult against a plain x*y reference.
module tb_kara_seq_mult;
    localparam int unsigned K  = 64;
    localparam int unsigned ZW = 2 * K;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [K-1:0]  x, y;
    logic          out_valid;
    logic          out_ready;
    logic [ZW-1:0] z;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    kara_seq_mult #(.K(K)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [ZW-1:0] obs, input logic [ZW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ZW-1:0] ref_mul(input logic [K-1:0] a, input logic [K-1:0] b);
        return ZW'(a) * ZW'(b);
    endfunction

    // One operation with out_ready high: checks accept, latency, product and return to idle
    task automatic run_op(input string tag, input logic [K-1:0] xv, input logic [K-1:0] yv);
        int n;
        @(negedge clk);
        x = xv; y = yv; in_valid = 1'b1; out_ready = 1'b1;
        check({tag, "_rdy"}, ZW'(in_ready), ZW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, ZW'(n), ZW'(4));
        check({tag, "_z"}, z, ref_mul(xv, yv));
        @(posedge clk); #1;
        check({tag, "_idle"}, ZW'(in_ready), ZW'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [K-1:0]  bx, by;
        logic [ZW-1:0] expq[$];
        int n, acc, done, cyc, last;
        bit seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", ZW'(in_ready), ZW'(1));
        check("rst_out_valid", ZW'(out_valid), ZW'(0));
        check("rst_busy", ZW'(busy), ZW'(0));
        check("rst_z", z, '0);

        run_op("small", 64'h3, 64'h5);
        run_op("max", '1, '1);
        run_op("pow", 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000);
        run_op("zero", '0, '1);

        // Backpressure: hold out_ready low in DONE with in_valid held high
        bx = 64'h1234_5678_9ABC_DEF0; by = 64'hFEDC_BA98_7654_3210;
        @(negedge clk);
        x = bx; y = by; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_lat", ZW'(n), ZW'(4));
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_z", z, ref_mul(bx, by));
            check("bp_valid", ZW'(out_valid), ZW'(1));
            check("bp_in_ready", ZW'(in_ready), ZW'(0));
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", ZW'(in_ready), ZW'(1));
        check("bp_release_valid", ZW'(out_valid), ZW'(0));

        // Reset while the t product is being formed
        @(negedge clk);
        x = {$urandom, $urandom}; y = {$urandom, $urandom}; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mrst_z", z, '0);
        check("mrst_in_ready", ZW'(in_ready), ZW'(1));
        check("mrst_busy", ZW'(busy), ZW'(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("mrst_no_valid", ZW'(seen), ZW'(0));
        check("mrst_ready_after", ZW'(in_ready), ZW'(1));
        run_op("after_rst", {$urandom, $urandom}, {$urandom, $urandom});

        // Back-to-back random traffic, in_valid held high, random backpressure
        acc = 0; done = 0; cyc = 0; last = -100;
        @(negedge clk);
        in_valid = 1'b1;
        while (done < 200 && cyc < 20000) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (acc >= 200) in_valid = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (out_valid && out_ready) begin
                check("rnd_pending", ZW'(expq.size() > 0), ZW'(1));
                if (expq.size() > 0) check("rnd_z", z, expq.pop_front());
                done++;
            end
            if (in_ready && in_valid) begin
                if (acc > 0) check("rnd_gap", ZW'((cyc - last) >= 6), ZW'(1));
                last = cyc;
                acc++;
                expq.push_back(ref_mul(x, y));
            end
        end
        check("rnd_done", ZW'(done), ZW'(200));
        check("rnd_drained", ZW'(expq.size()), ZW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
